// File: rtl/axi_lite_credit_buffer_if.sv
// AXI4-Lite bundle shared by both sides of the credit buffer.
// The master modport drives requests; the slave modport drives responses.
interface axi_lite_interface #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_credit_buffer.sv
// AXI4-Lite elastic buffer with per-channel FIFOs and outstanding-transaction
// credits that keep the B and R buffers able to absorb every slave response.

// First-word fall-through FIFO for any depth; depth 0 wires straight through.
module axi_lite_credit_buffer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    generate
        if (DEPTH == 0) begin : g_pass
            logic clk_rst_unused_s;

            assign clk_rst_unused_s = clk ^ rst_n;
            assign in_ready         = out_ready;
            assign out_valid        = in_valid;
            assign out_data         = in_data;
        end else begin : g_buf
            localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
            localparam int CNT_W = $clog2(DEPTH + 1);
            localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
            localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
            localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
            localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
            localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
            localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

            logic [WIDTH-1:0] mem_r [DEPTH];
            logic [PTR_W-1:0] wr_ptr_r;
            logic [PTR_W-1:0] rd_ptr_r;
            logic [CNT_W-1:0] count_r;
            logic             push_s;
            logic             pop_s;

            assign in_ready  = (count_r != CNT_FULL);
            assign out_valid = (count_r != CNT_ZERO);
            assign out_data  = mem_r[rd_ptr_r];
            assign push_s    = in_valid & in_ready;
            assign pop_s     = out_valid & out_ready;

            // Pointers wrap explicitly at DEPTH-1 so non power-of-two depths work.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    wr_ptr_r <= PTR_ZERO;
                    rd_ptr_r <= PTR_ZERO;
                    count_r  <= CNT_ZERO;
                end else begin
                    if (push_s) begin
                        wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? PTR_ZERO : wr_ptr_r + PTR_ONE;
                    end
                    if (pop_s) begin
                        rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? PTR_ZERO : rd_ptr_r + PTR_ONE;
                    end
                    case ({push_s, pop_s})
                        2'b10:   count_r <= count_r + CNT_ONE;
                        2'b01:   count_r <= count_r - CNT_ONE;
                        default: count_r <= count_r;
                    endcase
                end
            end

            // Payload storage; contents are don't-care until the count covers them.
            always_ff @(posedge clk) begin
                if (push_s) begin
                    mem_r[wr_ptr_r] <= in_data;
                end
            end
        end
    endgenerate
endmodule

module axi_lite_credit_buffer #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int AW_DEPTH   = 4,
    parameter int W_DEPTH    = 4,
    parameter int AR_DEPTH   = 4,
    parameter int B_DEPTH    = 4,
    parameter int R_DEPTH    = 4,
    parameter int MAX_WR     = B_DEPTH,
    parameter int MAX_RD     = R_DEPTH
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    axi_lite_interface.slave             to_master,
    axi_lite_interface.master            to_slave,
    output logic [$clog2(MAX_WR+1)-1:0]  wr_outstanding,
    output logic [$clog2(MAX_RD+1)-1:0]  rd_outstanding
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int W_WIDTH    = DATA_WIDTH + STRB_WIDTH;
    localparam int R_WIDTH    = DATA_WIDTH + 2;
    // Response buffers must hold at least one entry and credits may never exceed them.
    localparam int B_DEPTH_E  = (B_DEPTH < 1) ? 1 : B_DEPTH;
    localparam int R_DEPTH_E  = (R_DEPTH < 1) ? 1 : R_DEPTH;
    localparam int MAX_WR_E   = (MAX_WR < 1) ? 1 : ((MAX_WR > B_DEPTH_E) ? B_DEPTH_E : MAX_WR);
    localparam int MAX_RD_E   = (MAX_RD < 1) ? 1 : ((MAX_RD > R_DEPTH_E) ? R_DEPTH_E : MAX_RD);
    localparam int WR_CNT_W   = $clog2(MAX_WR + 1);
    localparam int RD_CNT_W   = $clog2(MAX_RD + 1);
    localparam logic [WR_CNT_W-1:0] WR_ZERO = WR_CNT_W'(0);
    localparam logic [WR_CNT_W-1:0] WR_ONE  = WR_CNT_W'(1);
    localparam logic [WR_CNT_W-1:0] WR_MAX  = WR_CNT_W'(MAX_WR_E);
    localparam logic [RD_CNT_W-1:0] RD_ZERO = RD_CNT_W'(0);
    localparam logic [RD_CNT_W-1:0] RD_ONE  = RD_CNT_W'(1);
    localparam logic [RD_CNT_W-1:0] RD_MAX  = RD_CNT_W'(MAX_RD_E);

    logic                  run_s;
    logic [WR_CNT_W-1:0]   wr_out_r;
    logic [RD_CNT_W-1:0]   rd_out_r;
    logic                  wr_credit_ok_s;
    logic                  rd_credit_ok_s;
    logic                  aw_acc_s;
    logic                  b_done_s;
    logic                  ar_acc_s;
    logic                  r_done_s;

    logic                  aw_in_valid_s;
    logic                  aw_in_ready_s;
    logic                  aw_out_valid_s;
    logic [ADDR_WIDTH-1:0] aw_out_data_s;
    logic                  w_in_ready_s;
    logic                  w_out_valid_s;
    logic [W_WIDTH-1:0]    w_out_data_s;
    logic                  ar_in_valid_s;
    logic                  ar_in_ready_s;
    logic                  ar_out_valid_s;
    logic [ADDR_WIDTH-1:0] ar_out_data_s;
    logic                  b_in_ready_unused_s;
    logic                  b_out_valid_s;
    logic [1:0]            b_out_data_s;
    logic                  r_in_ready_unused_s;
    logic                  r_out_valid_s;
    logic [R_WIDTH-1:0]    r_out_data_s;

    assign run_s          = ap_rst_n;
    assign wr_credit_ok_s = (wr_out_r < WR_MAX);
    assign rd_credit_ok_s = (rd_out_r < RD_MAX);

    // The credit gate is folded into the push so a held AWVALID/ARVALID cannot slip in.
    assign aw_in_valid_s     = run_s & to_master.awvalid & wr_credit_ok_s;
    assign ar_in_valid_s     = run_s & to_master.arvalid & rd_credit_ok_s;
    assign to_master.awready = run_s & aw_in_ready_s & wr_credit_ok_s;
    assign to_master.arready = run_s & ar_in_ready_s & rd_credit_ok_s;
    assign to_master.wready  = run_s & w_in_ready_s;
    assign to_master.bvalid  = run_s & b_out_valid_s;
    assign to_master.bresp   = b_out_data_s;
    assign to_master.rvalid  = run_s & r_out_valid_s;
    assign {to_master.rresp, to_master.rdata} = r_out_data_s;

    assign to_slave.awvalid = run_s & aw_out_valid_s;
    assign to_slave.awaddr  = aw_out_data_s;
    assign to_slave.wvalid  = run_s & w_out_valid_s;
    assign {to_slave.wstrb, to_slave.wdata} = w_out_data_s;
    assign to_slave.arvalid = run_s & ar_out_valid_s;
    assign to_slave.araddr  = ar_out_data_s;
    // Credits guarantee room, so responses are always accepted; the FIFO still drops a rogue extra beat rather than overwrite.
    assign to_slave.bready  = run_s;
    assign to_slave.rready  = run_s;

    assign aw_acc_s = to_master.awvalid & to_master.awready;
    assign ar_acc_s = to_master.arvalid & to_master.arready;
    assign b_done_s = to_master.bvalid & to_master.bready;
    assign r_done_s = to_master.rvalid & to_master.rready;

    assign wr_outstanding = wr_out_r;
    assign rd_outstanding = rd_out_r;

    axi_lite_credit_buffer_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(AW_DEPTH)) u_aw_fifo (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .in_valid  (aw_in_valid_s),
        .in_ready  (aw_in_ready_s),
        .in_data   (to_master.awaddr),
        .out_valid (aw_out_valid_s),
        .out_ready (run_s & to_slave.awready),
        .out_data  (aw_out_data_s)
    );

    axi_lite_credit_buffer_fifo #(.WIDTH(W_WIDTH), .DEPTH(W_DEPTH)) u_w_fifo (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .in_valid  (run_s & to_master.wvalid),
        .in_ready  (w_in_ready_s),
        .in_data   ({to_master.wstrb, to_master.wdata}),
        .out_valid (w_out_valid_s),
        .out_ready (run_s & to_slave.wready),
        .out_data  (w_out_data_s)
    );

    axi_lite_credit_buffer_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(AR_DEPTH)) u_ar_fifo (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .in_valid  (ar_in_valid_s),
        .in_ready  (ar_in_ready_s),
        .in_data   (to_master.araddr),
        .out_valid (ar_out_valid_s),
        .out_ready (run_s & to_slave.arready),
        .out_data  (ar_out_data_s)
    );

    axi_lite_credit_buffer_fifo #(.WIDTH(2), .DEPTH(B_DEPTH_E)) u_b_fifo (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .in_valid  (run_s & to_slave.bvalid),
        .in_ready  (b_in_ready_unused_s),
        .in_data   (to_slave.bresp),
        .out_valid (b_out_valid_s),
        .out_ready (run_s & to_master.bready),
        .out_data  (b_out_data_s)
    );

    axi_lite_credit_buffer_fifo #(.WIDTH(R_WIDTH), .DEPTH(R_DEPTH_E)) u_r_fifo (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .in_valid  (run_s & to_slave.rvalid),
        .in_ready  (r_in_ready_unused_s),
        .in_data   ({to_slave.rresp, to_slave.rdata}),
        .out_valid (r_out_valid_s),
        .out_ready (run_s & to_master.rready),
        .out_data  (r_out_data_s)
    );

    // Write credit: up on upstream AW accept, down on upstream B delivery, saturating both ways.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            wr_out_r <= WR_ZERO;
        end else if (aw_acc_s && !b_done_s) begin
            if (wr_out_r != WR_MAX) begin
                wr_out_r <= wr_out_r + WR_ONE;
            end
        end else if (b_done_s && !aw_acc_s) begin
            if (wr_out_r != WR_ZERO) begin
                wr_out_r <= wr_out_r - WR_ONE;
            end
        end
    end

    // Read credit: same rule with AR accept and R delivery.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            rd_out_r <= RD_ZERO;
        end else if (ar_acc_s && !r_done_s) begin
            if (rd_out_r != RD_MAX) begin
                rd_out_r <= rd_out_r + RD_ONE;
            end
        end else if (r_done_s && !ar_acc_s) begin
            if (rd_out_r != RD_ZERO) begin
                rd_out_r <= rd_out_r - RD_ONE;
            end
        end
    end
endmodule
